// File: rtl/bluetooth_rx_pkg.sv
// Shared types and timing helpers for the Bluetooth-link UART receiver.
// Bit timing is derived from the clock and line rates in one place.
package bluetooth_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int unsigned DEF_CLK_FREQ = 100_000_000;
  localparam int unsigned DEF_BAUD     = 9600;

  function automatic int unsigned calc_bit_ticks(input int unsigned clk_freq,
                                                 input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned calc_half_ticks(input int unsigned clk_freq,
                                                  input int unsigned baud);
    return calc_bit_ticks(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/bluetooth_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit single sampling, and a
// toggle flag (oState) that flips once per correctly framed byte.
module bluetooth_rx
  import bluetooth_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic      iClk,
  input  logic      iRst,
  input  logic      iRX,
  output logic [7:0] oData,
  output logic      oState,
  output rx_state_t oDbgState
);

  localparam int unsigned BIT_TICKS  = calc_bit_ticks(CLK_FREQ, BAUD);
  localparam int unsigned HALF_TICKS = calc_half_ticks(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W      = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);

  rx_state_t        state;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             fall;

  // rx_prev is the synchronized line one cycle earlier; all three reset high
  // so a line held low through reset is seen as a fresh start edge.
  assign fall      = rx_prev & ~rx_s2;
  assign oDbgState = state;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      oData   <= '0;
      oState  <= 1'b0;
    end else begin
      rx_s1   <= iRX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;

      case (state)
        S_IDLE: begin
          if (fall) begin
            cnt   <= '0;
            state <= S_START;
          end
        end

        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line back high at mid start bit was only a glitch.
            state   <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s2, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s2) begin
              oData  <= shreg;
              oState <= ~oState;
              state  <= S_IDLE;
            end else begin
              state <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (rx_s2) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bluetooth_rx.sv
// Bench for bluetooth_rx at 16 clocks per bit: directed scenarios followed by
// random frames, glitches and framing errors, checked by a toggle-driven monitor.
module tb_bluetooth_rx;
  import bluetooth_rx_pkg::*;

  localparam int unsigned CLK_FREQ = 16;
  localparam int unsigned BAUD     = 1;
  localparam int BIT  = 16;
  localparam int HALF = 8;
  // Raw edge -> 2 sync stages -> half bit + 9 bits -> output register.
  localparam int LAT  = HALF + 9 * BIT + 3;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      rx  = 1'b1;
  logic [7:0] data;
  logic      st;
  rx_state_t dbg;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  bit         exp_state = 1'b0;
  logic [7:0] last_good = 8'h00;

  bit         rst_flag  = 1'b0;
  logic       mon_state = 1'b0;
  logic [7:0] mon_data  = 8'h00;
  logic [7:0] pop_data;
  int         pop_cyc;

  bluetooth_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .iClk     (clk),
    .iRst     (rst),
    .iRX      (rx),
    .oData    (data),
    .oState   (st),
    .oDbgState(dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every toggle of oState must match the oldest expected byte
  always @(negedge clk) begin
    if (rst_flag || rst) begin
      mon_state = 1'b0;
      mon_data  = 8'h00;
    end else if (st !== mon_state) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_toggle: got byte %0h expected no output (cycle %0d)", data, cyc);
      end else begin
        pop_data = exp_q.pop_front();
        pop_cyc  = exp_cyc_q.pop_front();
        check("rx_byte", 32'(data), 32'(pop_data));
        check("rx_latency", 32'(cyc), 32'(pop_cyc));
      end
      mon_state = st;
      mon_data  = data;
    end else if (data !== mon_data) begin
      vectors++;
      errors++;
      $display("FAIL data_without_toggle: got %0h expected %0h (cycle %0d)", data, mon_data, cyc);
      mon_data = data;
    end
  end

  // driver tasks: all start and end aligned to a falling clock edge
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stop_len);
    if (stop_ok) begin
      exp_q.push_back(d);
      exp_cyc_q.push_back(cyc + LAT);
      exp_state = ~exp_state;
      last_good = d;
    end
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (stop_len) @(negedge clk);
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    idle(HALF + 4);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic check_outputs(input string name);
    check({name, "_data"}, 32'(data), 32'(last_good));
    check({name, "_state"}, 32'(st), 32'(exp_state));
  endtask

  initial begin
    int kind;
    logic [7:0] b;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("reset_data", 32'(data), 32'h00);
    check("reset_state", 32'(st), 32'h0);
    check("reset_fsm", 32'(dbg), 32'(S_IDLE));

    // long idle line
    for (int i = 0; i < 20; i++) begin
      idle(50);
      check_outputs("idle");
    end

    send_frame(8'h55, 1'b1, 0);
    idle(20);
    drain();
    check_outputs("frame55");

    send_frame(8'hA3, 1'b1, 0);
    send_frame(8'hA3, 1'b1, 0);
    idle(10);
    drain();
    check_outputs("b2b_a3");

    glitch(3);
    check_outputs("glitch");
    idle(30);
    send_frame(8'h12, 1'b1, 0);
    idle(10);
    drain();
    check_outputs("after_glitch");

    send_frame(8'hFF, 1'b0, 20);
    check_outputs("framing_err");
    idle(20);
    send_frame(8'h3C, 1'b1, 0);
    idle(10);
    drain();
    check_outputs("after_ferr");

    // reset during data bit 4 of a 0x81 frame
    send_frame(8'h7E, 1'b1, 0);
    idle(10);
    drain();
    check_outputs("frame7e");
    b = 8'h81;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[4];
    repeat (HALF) @(negedge clk);
    rst_flag = 1'b1;
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_state = 1'b0;
    last_good = 8'h00;
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_state", 32'(st), 32'h0);
    check("midrst_fsm", 32'(dbg), 32'(S_IDLE));
    @(negedge clk);
    rst_flag = 1'b0;
    idle(3 * BIT);
    send_frame(8'h81, 1'b1, 0);
    idle(10);
    drain();
    check_outputs("after_rst");

    // random mix of good frames, framing errors and short glitches
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      b    = 8'($urandom_range(0, 255));
      if (kind == 0) begin
        glitch($urandom_range(1, HALF - 1));
      end else if (kind == 1) begin
        send_frame(b, 1'b0, $urandom_range(1, 30));
      end else begin
        send_frame(b, 1'b1, 0);
      end
      idle($urandom_range(0, 40));
    end
    idle(20);
    drain();
    check_outputs("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
